// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - round-robin scheduler feeding ball-pair collisions to one resolver
// Samples the three pair-hit flags each physics frame, masks pairs in cooldown,
// grants the remaining pairs one at a time over valid/ready + done, then pulses step_done.
module collision_scheduler #(
  parameter int COOLDOWN_FRAMES = 4,
  parameter int CD_W            = 3,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int TO_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [2:0] hit_flags,
  output logic       res_valid,
  output logic [1:0] res_pair,
  input  logic       res_ready,
  input  logic       res_done,
  output logic       busy,
  output logic       step_done,
  output logic [2:0] cooling,
  output logic       tick_overrun,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      pending_q, pending_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic [CD_W-1:0] cd_q [3];
  logic [CD_W-1:0] cd_d [3];
  logic            res_valid_q, res_valid_d;
  logic [1:0]      res_pair_q, res_pair_d;
  logic            step_done_q, step_done_d;
  logic            tick_overrun_q, tick_overrun_d;
  logic            timeout_err_q, timeout_err_d;

  logic [2:0]      cool_vec;
  logic [2:0]      masked;
  logic [1:0]      sel;
  logic [2:0]      grant_clr;
  logic            load_en;
  logic            to_set;
  logic            overrun_set;

  // First requesting pair found when scanning 0..2 cyclically starting at ptr.
  // The scan runs from the farthest offset down so the nearest one wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [2:0] s;
    pick = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      s = {1'b0, ptr} + 3'(k);
      if (s >= 3'd3) s = s - 3'd3;
      if (req[s[1:0]]) pick = s[1:0];
    end
    return pick;
  endfunction

  // Cooldown view of each pair and the frame's eligible hits (pre-decrement).
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cool_vec[i] = (cd_q[i] != '0);
    end
    masked = hit_flags & ~cool_vec;
    sel    = rr_pick(pending_q, rr_ptr_q);
  end

  // Next-state logic: handshake FSM, pending set, cooldown counters and sticky errors.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    res_valid_d = res_valid_q;
    res_pair_d  = res_pair_q;
    step_done_d = 1'b0;
    grant_clr   = 3'b000;
    load_en     = 1'b0;
    to_set      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_tick) state_d = S_ARB;
      end
      S_ARB: begin
        if (pending_q == 3'b000) begin
          step_done_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          res_pair_d     = sel;
          res_valid_d    = 1'b1;
          grant_clr[sel] = 1'b1;
          rr_ptr_d       = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
          timer_d        = '0;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = timer_q + 1'b1;
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_WAIT;
        end else if (timer_q == TO_LAST) begin
          to_set      = 1'b1;
          res_valid_d = 1'b0;
          load_en     = 1'b1;
          state_d     = S_ARB;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (res_done) begin
          load_en = 1'b1;
          state_d = S_ARB;
        end else if (timer_q == TO_LAST) begin
          to_set  = 1'b1;
          load_en = 1'b1;
          state_d = S_ARB;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A tick mid-round merges into the current round; a re-hit re-sets a bit granted this cycle.
    if (state_q == S_IDLE) begin
      pending_d = frame_tick ? masked : pending_q;
    end else begin
      pending_d = (pending_q & ~grant_clr) | (frame_tick ? masked : 3'b000);
    end
    overrun_set = frame_tick && (state_q != S_IDLE);

    // Service load overrides the frame decrement on the same edge.
    for (int i = 0; i < 3; i++) begin
      cd_d[i] = cd_q[i];
      if (frame_tick && (cd_q[i] != '0)) cd_d[i] = cd_q[i] - 1'b1;
      if (load_en && (res_pair_q == 2'(i))) cd_d[i] = CD_LOAD;
    end

    tick_overrun_d = overrun_set | (tick_overrun_q & ~err_clr);
    timeout_err_d  = to_set | (timeout_err_q & ~err_clr);
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pending_q      <= 3'b000;
      rr_ptr_q       <= 2'd0;
      timer_q        <= '0;
      res_valid_q    <= 1'b0;
      res_pair_q     <= 2'd0;
      step_done_q    <= 1'b0;
      tick_overrun_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cd_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      rr_ptr_q       <= rr_ptr_d;
      timer_q        <= timer_d;
      res_valid_q    <= res_valid_d;
      res_pair_q     <= res_pair_d;
      step_done_q    <= step_done_d;
      tick_overrun_q <= tick_overrun_d;
      timeout_err_q  <= timeout_err_d;
      for (int i = 0; i < 3; i++) begin
        cd_q[i] <= cd_d[i];
      end
    end
  end

  assign res_valid    = res_valid_q;
  assign res_pair     = res_pair_q;
  assign busy         = (state_q != S_IDLE);
  assign step_done    = step_done_q;
  assign cooling      = cool_vec;
  assign tick_overrun = tick_overrun_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// tb/tb_collision_scheduler.sv - self-checking bench for collision_scheduler
module tb_collision_scheduler;

  localparam int COOL = 4;
  localparam int TO   = 255;

  localparam int P_IDLE  = 0;
  localparam int P_ARB   = 1;
  localparam int P_ISSUE = 2;
  localparam int P_WAIT  = 3;
  localparam int P_DONE  = 4;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       frame_tick = 1'b0;
  logic [2:0] hit_flags  = 3'b000;
  logic       res_ready  = 1'b0;
  logic       res_done   = 1'b0;
  logic       err_clr    = 1'b0;
  logic       res_valid;
  logic [1:0] res_pair;
  logic       busy;
  logic       step_done;
  logic [2:0] cooling;
  logic       tick_overrun;
  logic       timeout_err;

  collision_scheduler #(
    .COOLDOWN_FRAMES(COOL),
    .CD_W(3),
    .TIMEOUT_CYCLES(TO),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .hit_flags(hit_flags),
    .res_valid(res_valid),
    .res_pair(res_pair),
    .res_ready(res_ready),
    .res_done(res_done),
    .busy(busy),
    .step_done(step_done),
    .cooling(cooling),
    .tick_overrun(tick_overrun),
    .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame/transaction rules) ----------------
  int       m_phase   = P_IDLE;
  bit [2:0] m_pending = 3'b000;
  int       m_rr      = 0;
  int       m_timer   = 0;
  int       m_cd [3]  = '{0, 0, 0};
  bit       m_valid   = 1'b0;
  int       m_pair    = 0;
  bit       m_ov      = 1'b0;
  bit       m_to      = 1'b0;

  always @(posedge clk or posedge rst) begin : model_blk
    bit [2:0] cool_v;
    bit [2:0] masked_v;
    bit [2:0] pend;
    int       load;
    int       nph;
    int       p;
    bit       to_set;
    bit       ov_set;
    if (rst) begin
      m_phase   = P_IDLE;
      m_pending = 3'b000;
      m_rr      = 0;
      m_timer   = 0;
      for (int i = 0; i < 3; i++) m_cd[i] = 0;
      m_valid   = 1'b0;
      m_pair    = 0;
      m_ov      = 1'b0;
      m_to      = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) cool_v[i] = (m_cd[i] != 0);
      masked_v = hit_flags & ~cool_v;
      pend     = m_pending;
      load     = -1;
      nph      = m_phase;
      to_set   = 1'b0;
      ov_set   = 1'b0;
      case (m_phase)
        P_IDLE: if (frame_tick) begin pend = masked_v; nph = P_ARB; end
        P_ARB: begin
          if (pend == 3'b000) begin
            nph = P_DONE;
          end else begin
            p = -1;
            for (int k = 0; k < 3; k++) if (p < 0 && pend[(m_rr + k) % 3]) p = (m_rr + k) % 3;
            m_pair  = p;
            m_valid = 1'b1;
            pend[p] = 1'b0;
            m_rr    = (p + 1) % 3;
            m_timer = 0;
            nph     = P_ISSUE;
          end
        end
        P_ISSUE: begin
          if (res_ready) begin
            m_valid = 1'b0; nph = P_WAIT;
          end else if (m_timer == TO - 1) begin
            to_set = 1'b1; m_valid = 1'b0; load = m_pair; nph = P_ARB;
          end
          m_timer++;
        end
        P_WAIT: begin
          if (res_done) begin
            load = m_pair; nph = P_ARB;
          end else if (m_timer == TO - 1) begin
            to_set = 1'b1; load = m_pair; nph = P_ARB;
          end
          m_timer++;
        end
        default: nph = P_IDLE;
      endcase
      if (frame_tick && m_phase != P_IDLE) begin
        pend   = pend | masked_v;
        ov_set = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if (frame_tick && m_cd[i] > 0) m_cd[i]--;
        if (load == i) m_cd[i] = COOL;
      end
      m_pending = pend;
      m_phase   = nph;
      m_ov      = ov_set | (m_ov & !err_clr);
      m_to      = to_set | (m_to & !err_clr);
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk("res_valid", res_valid, m_valid);
    chk("res_pair", res_pair, m_pair);
    chk("busy", busy, m_phase != P_IDLE);
    chk("step_done", step_done, m_phase == P_DONE);
    chk("cooling", cooling, {m_cd[2] != 0, m_cd[1] != 0, m_cd[0] != 0});
    chk("tick_overrun", tick_overrun, m_ov);
    chk("timeout_err", timeout_err, m_to);
  end

  // ---------------- grant log and step_done counter ----------------
  int grants [$];
  bit prev_v   = 1'b0;
  int sd_count = 0;
  always @(negedge clk) begin
    if (res_valid === 1'b1 && !prev_v) grants.push_back(int'(res_pair));
    prev_v = (res_valid === 1'b1);
    if (step_done === 1'b1) sd_count++;
  end

  // ---------------- resolver responder ----------------
  bit rsp_ready = 1'b0;
  int rsp_delay = 1;
  int done_cnt  = 0;
  initial begin : responder
    bit acc;
    forever begin
      @(negedge clk);
      acc = (res_valid === 1'b1) && (res_ready === 1'b1);
      @(posedge clk);
      #1;
      res_ready = rsp_ready;
      res_done  = 1'b0;
      if (acc) done_cnt = rsp_delay;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) res_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic [2:0] flags);
    @(posedge clk);
    #1;
    frame_tick = 1'b1;
    hit_flags  = flags;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_idle_in_time"}, k < 1000, 1);
  endtask

  task automatic wait_valid(input string nm);
    int k;
    k = 0;
    while (!(res_valid === 1'b1) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_valid_in_time"}, k < 40, 1);
  endtask

  task automatic flush();
    repeat (COOL) begin
      tick(3'b000);
      wait_idle("flush");
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_seq(input string nm, input int n, input int e0, input int e1, input int e2);
    int e [3];
    e = '{e0, e1, e2};
    chk({nm, "_len"}, grants.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < grants.size()) chk($sformatf("%s_%0d", nm, i), grants[i], e[i]);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    int cnt;
    int bad;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_cooling", cooling, 0);

    // Zero hits: step_done exactly two cycles after the tick, no grant.
    grants.delete();
    tick(3'b000);
    @(negedge clk);
    chk("t1_busy_c1", busy, 1);
    chk("t1_sd_c1", step_done, 0);
    @(negedge clk);
    chk("t1_sd_c2", step_done, 1);
    @(negedge clk);
    chk("t1_sd_c3", step_done, 0);
    chk("t1_busy_c3", busy, 0);
    chk("t1_no_grant", grants.size(), 0);

    // Round-robin: 101 -> 0,2; after cooldown expires 111 -> 0,1,2.
    rsp_ready = 1'b1;
    rsp_delay = 1;
    grants.delete();
    tick(3'b101);
    wait_idle("t2a");
    chk_seq("t2_rr", 2, 0, 2, 0);
    flush();
    grants.delete();
    tick(3'b111);
    wait_idle("t2b");
    chk_seq("t2_rr3", 3, 0, 1, 2);
    flush();

    // Cooldown: pair 0 blocked for four frames, granted on the fifth.
    grants.delete();
    tick(3'b001);
    wait_idle("t3a");
    for (int f = 1; f <= 4; f++) begin
      chk($sformatf("t3_cool%0d", f), cooling[0], 1);
      tick(3'b001);
      wait_idle("t3b");
    end
    chk("t3_cool5", cooling[0], 0);
    tick(3'b001);
    wait_idle("t3c");
    chk_seq("t3_grants", 2, 0, 0, 0);
    flush();

    // Stalled resolver: request held TIMEOUT_CYCLES cycles, then aborted.
    rsp_ready = 1'b0;
    grants.delete();
    tick(3'b010);
    wait_valid("t4");
    cnt = 0;
    bad = 0;
    do begin
      if (res_pair !== 2'd1) bad++;
      cnt++;
      @(negedge clk);
    end while (res_valid === 1'b1 && cnt < 400);
    chk("t4_hold_cycles", cnt, TO);
    chk("t4_pair_stable", bad, 0);
    chk("t4_timeout_err", timeout_err, 1);
    chk("t4_cooling1", cooling[1], 1);
    sd_count = 0;
    wait_idle("t4");
    chk("t4_step_done", sd_count, 1);
    pulse_clr();
    chk("t4_err_cleared", timeout_err, 0);
    rsp_ready = 1'b1;
    flush();

    // Overrun: tick during WAIT on pair 0 adds pair 1 to the same round.
    rsp_delay = 4;
    grants.delete();
    sd_count = 0;
    tick(3'b001);
    cnt = 0;
    while (!(res_valid === 1'b1 && res_ready === 1'b1) && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("t5_accept_in_time", cnt < 40, 1);
    tick(3'b010);
    wait_idle("t5");
    chk_seq("t5_grants", 2, 0, 1, 0);
    chk("t5_overrun", tick_overrun, 1);
    chk("t5_one_step_done", sd_count, 1);
    pulse_clr();
    chk("t5_overrun_cleared", tick_overrun, 0);
    rsp_delay = 1;
    flush();

    // Async reset mid-ISSUE clears the request and all cooldown at once.
    grants.delete();
    tick(3'b100);
    wait_idle("t6a");
    chk("t6_pre_cool2", cooling[2], 1);
    rsp_ready = 1'b0;
    tick(3'b001);
    wait_valid("t6");
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", res_valid, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_cool", cooling, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    grants.delete();
    tick(3'b100);
    wait_idle("t6b");
    chk_seq("t6_grant", 1, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
